axis_sequence_checker: RTL

- Downstream consumer of the free-running AXI4-Stream counter source; verifies that every accepted word equals the previous accepted word + 1 (modulo 2^AXIS_TDATA_WIDTH).
- Passes the stream through unchanged to the next stage and exposes registered status: word count, error count, lock flag.
- Used in loopback/DMA bring-up to detect dropped, duplicated or corrupted words.

---
 rtl/axis_sequence_checker.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/axis_sequence_checker.sv
// ---------------------------------------------------------------------------
// axis_sequence_checker
//
// Sits downstream of a free-running AXI4-Stream counter source and checks that
// every accepted word equals the previously accepted word + 1, modulo
// 2^AXIS_TDATA_WIDTH. The stream itself passes straight through with no
// latency and is never stalled by the checker. Loss, duplication or corruption
// of words shows up in the status counters.
//
// Optional build macro:
//   AXIS_SEQUENCE_CHECKER_CAPTURE_EN  - when defined, the expected value, the
//                                       received value and the word index of
//                                       the first sequence error after reset
//                                       are captured on the sts_bad_* ports.
//                                       When undefined those ports read 0 and
//                                       no capture registers exist.
//
// Parameters:
//   AXIS_TDATA_WIDTH  stream data width, also the width of the expected value
//   CNTR_WIDTH        width of the word / error counters and the bad index
//
// Ports:
//   aclk              clock
//   areset            synchronous active-high reset (status only; the
//                     pass-through path ignores it)
//   s_axis_tdata/tvalid/tready   upstream AXI4-Stream slave
//   m_axis_tdata/tvalid/tready   downstream AXI4-Stream master (pass-through)
//   sts_words         accepted word count, wraps
//   sts_errors        sequence error count, saturates at all-ones
//   sts_locked        high once the first word has seeded the checker
//   sts_bad_expected  expected value at the first error
//   sts_bad_received  received value at the first error
//   sts_bad_index     0-based word index of the first error
// ---------------------------------------------------------------------------
module axis_sequence_checker #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [CNTR_WIDTH-1:0]       sts_words,
  output logic [CNTR_WIDTH-1:0]       sts_errors,
  output logic                        sts_locked,
  output logic [AXIS_TDATA_WIDTH-1:0] sts_bad_expected,
  output logic [AXIS_TDATA_WIDTH-1:0] sts_bad_received,
  output logic [CNTR_WIDTH-1:0]       sts_bad_index
);

  localparam logic [0:0] ST_SYNC  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  localparam logic [AXIS_TDATA_WIDTH-1:0] DATA_ONE = {{(AXIS_TDATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNTR_WIDTH-1:0]       CNT_ONE  = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNTR_WIDTH-1:0]       CNT_ZERO = '0;
  localparam logic [AXIS_TDATA_WIDTH-1:0] DATA_ZERO = '0;

  // Sequence arithmetic: the data value and word count wrap naturally, the
  // error count sticks at all-ones so a long bad run never reads as healthy.
  function automatic logic [AXIS_TDATA_WIDTH-1:0] data_wrap_inc(
    input logic [AXIS_TDATA_WIDTH-1:0] v
  );
    return v + DATA_ONE;
  endfunction

  function automatic logic [CNTR_WIDTH-1:0] cnt_wrap_inc(
    input logic [CNTR_WIDTH-1:0] v
  );
    return v + CNT_ONE;
  endfunction

  function automatic logic [CNTR_WIDTH-1:0] cnt_sat_inc(
    input logic [CNTR_WIDTH-1:0] v
  );
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  // ---- stage p0: combinational pass-through and transfer qualification ----
  logic xfer_p0;
  logic match_p0;
  logic mismatch_p0;

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = s_axis_tvalid;
  assign s_axis_tready = m_axis_tready;

  logic [0:0]                  state_p1;
  logic [AXIS_TDATA_WIDTH-1:0] expected_p1;
  logic [CNTR_WIDTH-1:0]       words_p1;
  logic [CNTR_WIDTH-1:0]       errors_p1;
  logic                        locked_p1;

  assign xfer_p0     = s_axis_tvalid & m_axis_tready;
  assign match_p0    = (s_axis_tdata == expected_p1);
  // A mismatch only counts once the checker has been seeded.
  assign mismatch_p0 = xfer_p0 & (state_p1 == ST_TRACK) & ~match_p0;

  // ---- stage p1: checker state and status registers ----
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_p1    <= ST_SYNC;
      expected_p1 <= DATA_ZERO;
      words_p1    <= CNT_ZERO;
      errors_p1   <= CNT_ZERO;
      locked_p1   <= 1'b0;
    end else if (xfer_p0) begin
      words_p1 <= cnt_wrap_inc(words_p1);
      case (state_p1)
        ST_SYNC: begin
          // First word seeds the sequence and is never judged.
          expected_p1 <= data_wrap_inc(s_axis_tdata);
          locked_p1   <= 1'b1;
          state_p1    <= ST_TRACK;
        end
        default: begin
          if (match_p0) begin
            expected_p1 <= data_wrap_inc(expected_p1);
          end else begin
            // Resync on the received word so one drop or duplicate costs
            // exactly one error instead of a cascade.
            errors_p1   <= cnt_sat_inc(errors_p1);
            expected_p1 <= data_wrap_inc(s_axis_tdata);
          end
        end
      endcase
    end
  end

  assign sts_words  = words_p1;
  assign sts_errors = errors_p1;
  assign sts_locked = locked_p1;

`ifdef AXIS_SEQUENCE_CHECKER_CAPTURE_EN
  logic                        captured_p1;
  logic [AXIS_TDATA_WIDTH-1:0] bad_expected_p1;
  logic [AXIS_TDATA_WIDTH-1:0] bad_received_p1;
  logic [CNTR_WIDTH-1:0]       bad_index_p1;

  // ---- stage p1: first-error capture, frozen until reset ----
  always_ff @(posedge aclk) begin
    if (areset) begin
      captured_p1     <= 1'b0;
      bad_expected_p1 <= DATA_ZERO;
      bad_received_p1 <= DATA_ZERO;
      bad_index_p1    <= CNT_ZERO;
    end else if (mismatch_p0 && !captured_p1) begin
      captured_p1     <= 1'b1;
      bad_expected_p1 <= expected_p1;
      bad_received_p1 <= s_axis_tdata;
      bad_index_p1    <= words_p1;
    end
  end

  assign sts_bad_expected = bad_expected_p1;
  assign sts_bad_received = bad_received_p1;
  assign sts_bad_index    = bad_index_p1;
`else
  logic unused_mismatch_p0;
  assign unused_mismatch_p0 = mismatch_p0;

  assign sts_bad_expected = DATA_ZERO;
  assign sts_bad_received = DATA_ZERO;
  assign sts_bad_index    = CNT_ZERO;
`endif

endmodule
